// File: rtl/alu_issue_ctrl.sv
// Issue controller sitting in front of a combinational ALU: decodes the op, registers the
// operands and control, waits EXEC_CYCLES for the ALU to settle, then captures the result.
module alu_issue_ctrl #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  ALUOp,
  input  logic [5:0]  Funct,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  input  logic [31:0] Imm,
  input  logic        ALUSrc,
  input  logic        Branch,
  output logic [31:0] OP1,
  output logic [31:0] OP2,
  output logic [3:0]  ALU_Control,
  input  logic [31:0] Salida,
  input  logic        ZF,
  output logic [31:0] Result,
  output logic        Zero,
  output logic        BranchTaken,
  output logic        IllegalOp,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] op1_q, op1_d, op2_q, op2_d;
  logic [3:0]  ctl_q, ctl_d;
  logic        branch_q, branch_d;
  logic [1:0]  aluop_q, aluop_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;
  logic        bt_q, bt_d;
  logic        ill_q, ill_d;

  logic [3:0]  dec_ctl;
  logic        dec_ok;

  always_comb begin
    dec_ctl = 4'b0000;
    dec_ok  = 1'b1;
    case (ALUOp)
      2'b00: dec_ctl = 4'b0010;
      2'b01: dec_ctl = 4'b0110;
      2'b10: begin
        case (Funct)
          6'b100000: dec_ctl = 4'b0010;
          6'b100010: dec_ctl = 4'b0110;
          6'b100100: dec_ctl = 4'b0000;
          6'b100101: dec_ctl = 4'b0001;
          6'b101010: dec_ctl = 4'b0111;
          default:   dec_ok  = 1'b0;
        endcase
      end
      default: dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    ctl_d    = ctl_q;
    branch_d = branch_q;
    aluop_d  = aluop_q;
    result_d = result_q;
    zero_d   = zero_q;
    bt_d     = bt_q;
    ill_d    = ill_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (dec_ok) begin
            op1_d    = RsData;
            op2_d    = ALUSrc ? Imm : RtData;
            ctl_d    = dec_ctl;
            branch_d = Branch;
            aluop_d  = ALUOp;
            cnt_d    = CNT_INIT;
            state_d  = S_EXEC;
          end else begin
            // Undecodable request: skip EXEC, previous results stay visible.
            ill_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d = Salida;
          zero_d   = ZF;
          bt_d     = branch_q & ZF & (aluop_q == 2'b01);
          ill_d    = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      op1_q    <= 32'd0;
      op2_q    <= 32'd0;
      ctl_q    <= 4'd0;
      branch_q <= 1'b0;
      aluop_q  <= 2'b00;
      result_q <= 32'd0;
      zero_q   <= 1'b0;
      bt_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      ctl_q    <= ctl_d;
      branch_q <= branch_d;
      aluop_q  <= aluop_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      bt_q     <= bt_d;
      ill_q    <= ill_d;
    end
  end

  assign OP1         = op1_q;
  assign OP2         = op2_q;
  assign ALU_Control = ctl_q;
  assign Result      = result_q;
  assign Zero        = zero_q;
  assign BranchTaken = bt_q;
  assign IllegalOp   = ill_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter EXEC_CYCLES, default 1, ALU settle cycles per operation, legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 ALUOp  input  2  class: 00 add (lw/sw), 01 sub (beq), 10 R-type via Funct, 11 reserved.
REQ-006 Funct  input  6  R-type function field.
REQ-007 RsData  input  32  first source operand.
REQ-008 RtData  input  32  second register operand.
REQ-009 Imm  input  32  sign-extended immediate.
REQ-010 ALUSrc  input  1  1 selects Imm as second operand, 0 selects RtData.
REQ-011 Branch  input  1  instruction is a conditional branch.
REQ-012 OP1  output  32  registered first operand to ALU.
REQ-013 OP2  output  32  registered second operand to ALU.
REQ-014 ALU_Control  output  4  registered ALU operation code.
REQ-015 Salida  input  32  ALU result (combinational from OP1/OP2/ALU_Control).
REQ-016 ZF  input  1  ALU zero flag.
REQ-017 Result  output  32  captured ALU result.
REQ-018 Zero  output  1  captured ZF.
REQ-019 BranchTaken  output  1  branch condition met.
REQ-020 IllegalOp  output  1  last request undecodable.
REQ-021 busy  output  1  high whenever state is not IDLE.
REQ-022 done  output  1  one-cycle completion pulse.

Function
REQ-023 Decode: ALUOp 00 -> 0010; 01 -> 0110; 10 with Funct 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111.
REQ-024 ALUOp 11, or ALUOp 10 with any other Funct, is illegal.
REQ-025 States: IDLE, EXEC, DONE; encoding free.
REQ-026 IDLE, start=1, legal op: on that edge load OP1=RsData, OP2=(ALUSrc?Imm:RtData), ALU_Control=decoded code, latch Branch and ALUOp, counter=EXEC_CYCLES-1, go EXEC.
REQ-027 IDLE, start=1, illegal op: OP1/OP2/ALU_Control unchanged, IllegalOp<=1, go DONE.
REQ-028 EXEC, counter!=0: decrement counter, stay EXEC; OP1/OP2/ALU_Control held stable.
REQ-029 EXEC, counter==0: capture Result<=Salida, Zero<=ZF, BranchTaken<=latched Branch & ZF & (latched ALUOp==01), IllegalOp<=0, go DONE.
REQ-030 DONE: done=1 for exactly this cycle; unconditionally go IDLE next edge.
REQ-031 Latency: legal op, start sampled at edge T -> done high during cycle after edge T+EXEC_CYCLES; illegal op -> done high cycle after edge T.
REQ-032 start while busy (EXEC or DONE) ignored, no queueing; back-to-back start accepted in first IDLE cycle after DONE.
REQ-033 Result, Zero, BranchTaken hold last captured values until next capture; illegal op leaves them unchanged.
REQ-034 BranchTaken 0 for any non-branch or non-ALUOp-01 capture.
REQ-035 Input changes during EXEC/DONE have no effect on outputs.
REQ-036 done and busy are registered-state outputs, glitch-free, no combinational path from start.

Reset
REQ-037 rst=1 at an edge: state IDLE, OP1=0, OP2=0, ALU_Control=0000, Result=0, Zero=0, BranchTaken=0, IllegalOp=0, counter=0; busy=0, done=0.
REQ-038 rst has priority over start and all transitions; reset mid-EXEC aborts with no done pulse and no capture.

Verification
REQ-039 Reset then idle -> all outputs 0, busy=0, done=0.
REQ-040 ALUOp=10, Funct=100010, Rs=10, Rt=10, EXEC_CYCLES=1 -> ALU_Control=0110, Result=0, Zero=1, done one cycle, BranchTaken=0.
REQ-041 ALUOp=01, Branch=1, Rs=7, Rt=7 -> BranchTaken=1; repeat with Rt=8 -> BranchTaken=0, Result=0xFFFFFFFF.
REQ-042 ALUOp=00, ALUSrc=1, Rs=0x100, Imm=0xFFFFFFFC -> OP2=Imm, Result=0xFC; start pulsed during EXEC ignored.
REQ-043 ALUOp=10, Funct=000000 after prior Result=5 -> IllegalOp=1, done next cycle, Result stays 5.
REQ-044 EXEC_CYCLES=4, rst asserted in 2nd EXEC cycle -> no done, all outputs at reset values.
